jk_ff_bist: RTL and testbench
=============================

# jk_ff_bist

Self-checking stimulus engine for a master-slave JK flip-flop: drives J/K into an external `ms_jk_ff`, samples Q/Qn, and compares them against an internal reference model.
- It runs a fixed directed sequence (hold/set/reset/toggle), then an optional LFSR-driven random phase.
- It reports pass/fail, an error count and the first failing step.
- It is the driver side of the flip-flop interface, used for on-chip self-test of the flip-flop cells.

## Interface
- `RAND_STEPS`, 16: number of LFSR-driven steps after the directed sequence; 0–239.
- `SEED`, 8'hA5: LFSR seed; the value 0 is replaced by 8'h01.
- `clk` in 1: single clock, rising-edge logic.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: single-cycle request to begin a run; honoured only in IDLE or DONE.
- `J` out 1: J drive to the flip-flop.
- `K` out 1: K drive to the flip-flop.
- `Q` in 1: flip-flop output.
- `Qn` in 1: flip-flop complement output.
- `busy` out 1: high from the first DRIVE through the last CHECK.
- `done` out 1: level, high in DONE until the next `start` or `rst`.
- `pass` out 1: valid when `done`=1; 1 if and only if `err_count`==0.
- `err_count` out 8: mismatch count, saturates at 255.
- `first_fail_step` out 8: index of the first mismatching step; 8'hFF if there is none.

## Operation
- FSM states: IDLE, DRIVE, WAIT, CHECK, DONE. Each step is DRIVE→WAIT→CHECK (3 cycles).
- IDLE/DONE + `start`:
  - go to DRIVE with step=0;
  - clear `err_count`, set `first_fail_step`=FF;
  - load the LFSR with SEED.
- DRIVE:
  - J/K = the step's pattern;
  - the model updates `exp` using the JK table: 00 hold, 01→0, 10→1, 11→~exp.
- WAIT and CHECK: J/K = 00 (hold), so the flip-flop captures only one non-hold pattern per step.
- CHECK:
  - Mismatch if Q≠exp or Qn≠~exp; this includes Q==Qn.
  - On mismatch: increment `err_count` (saturating). If this is the first error, latch step into `first_fail_step`.
  - Then step+1. Next state is DRIVE, or DONE if step was the last (16+RAND_STEPS−1).
- Directed patterns for steps 0–15 (J K): 01,00,00,10,00,11,11,11,11,01,10,11,00,01,11,00.
  - Step 0 is a reset, so the initial unknown Q is never compared against an undefined model.
  - Expected Q after each step: 0,0,0,1,1,0,1,0,1,0,1,0,0,0,1,1.
- Random steps: J/K = lfsr[1:0].
  - The LFSR uses x^8+x^6+x^5+x^4+1 and shifts once per random step, in CHECK.
- `start` while busy is ignored.
- `rst` at any time:
  - go to IDLE;
  - J=K=0, busy=done=pass=0;
  - err_count=0, first_fail_step=FF, step=0, exp=0.

## Timing
- All outputs are registered; J/K change only on the rising edge entering each state.
- Interface timing:
  - The flip-flop master samples J/K at the rising edge ending DRIVE.
  - The slave updates Q on the following falling edge.
  - The block registers Q/Qn at the rising edge ending WAIT.
  - The comparison happens in CHECK.
- Latency:
  - `busy` rises 1 cycle after `start`.
  - A run lasts 3×(16+RAND_STEPS) cycles; `done` rises on the cycle after the final CHECK. With the default 32 steps this is 96 cycles.
- `pass`, `err_count` and `first_fail_step` are stable whenever `done`=1.

## Structure
- Package `jk_bist_pkg` holds:
  - the state enum;
  - JK code constants JK_HOLD/JK_RST/JK_SET/JK_TGL;
  - the 16-entry directed-pattern constant array;
  - function `jk_next(q,j,k)`.
- Sub-module `jk_lfsr8`: 8-bit Galois LFSR with `load`, `seed` and `shift` inputs.
- Top level: FSM, step counter, reference model, error logic.

## Test plan
- Good `ms_jk_ff`, RAND_STEPS=0, pulse `start` → J/K sequence matches the directed list; `done` is reached after 48 cycles with pass=1, err_count=0, first_fail_step=FF.
- Faulty model with Q stuck at 0 and Qn=~Q, RAND_STEPS=0 → err_count=7, first_fail_step=3, pass=0.
- Faulty model with Qn tied to Q → every step mismatches: err_count=16, first_fail_step=0.
- Good flip-flop, RAND_STEPS=16, SEED=A5 → J/K on steps 16–31 equal the golden LFSR low bits; pass=1 after 96 cycles.
- `start` re-pulsed mid-run → ignored, run length unchanged. `rst` asserted during step 5 → next cycle IDLE, J=K=0, busy=0, err_count=0; a new `start` completes normally.
- A second `start` from DONE → counters clear and results reproduce identically.

Source files
------------

// File: rtl/jk_bist_pkg.sv
// rtl/jk_bist_pkg.sv - shared types, JK codes, directed patterns and JK next-state helper
package jk_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_WAIT,
      ST_CHECK,
      ST_DONE
   } state_t;

   // JK codes are packed {J, K}
   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_RST  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TGL  = 2'b11;

   localparam int DIR_STEPS = 16;

   // Step 0 is a reset so the flip-flop's power-up value never reaches a comparison
   localparam logic [1:0] DIR_PATTERN [DIR_STEPS] = '{
      JK_RST,  JK_HOLD, JK_HOLD, JK_SET,
      JK_HOLD, JK_TGL,  JK_TGL,  JK_TGL,
      JK_TGL,  JK_RST,  JK_SET,  JK_TGL,
      JK_HOLD, JK_RST,  JK_TGL,  JK_HOLD
   };

   // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic jk_next(input logic q, input logic j, input logic k);
      logic r;
      case ({j, k})
         JK_HOLD: r = q;
         JK_RST:  r = 1'b0;
         JK_SET:  r = 1'b1;
         default: r = ~q;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/jk_lfsr8.sv
// rtl/jk_lfsr8.sv - 8-bit Galois LFSR supplying random JK patterns
module jk_lfsr8
   import jk_bist_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] seed,
   input  logic       shift,
   output logic [1:0] out_bits,
   output logic [1:0] next_bits
);

   logic [7:0] state;
   logic [7:0] state_nxt;

   // One Galois step; the all-zero lockup state is never loaded
   always_comb begin
      state_nxt = state[0] ? ((state >> 1) ^ LFSR_TAPS) : (state >> 1);
   end

   assign out_bits  = state[1:0];
   assign next_bits = state_nxt[1:0];

   // Load has priority over shift; a zero seed is replaced by 1
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= 8'h01;
      end else if (load) begin
         state <= (seed == 8'h00) ? 8'h01 : seed;
      end else if (shift) begin
         state <= state_nxt;
      end
   end

endmodule

// File: rtl/jk_ff_bist.sv
// rtl/jk_ff_bist.sv - self-test driver and checker for a master-slave JK flip-flop
module jk_ff_bist
   import jk_bist_pkg::*;
#(
   parameter int         RAND_STEPS = 16,
   parameter logic [7:0] SEED       = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       J,
   output logic       K,
   input  logic       Q,
   input  logic       Qn,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic [7:0] first_fail_step
);

   localparam int         TOTAL_STEPS = DIR_STEPS + RAND_STEPS;
   localparam logic [7:0] LAST_STEP   = 8'(TOTAL_STEPS - 1);

   state_t     state;
   logic [7:0] step;
   logic [7:0] step_inc;
   logic       exp_q;
   logic       q_s;
   logic       qn_s;
   logic       mismatch;
   logic [7:0] err_inc;
   logic [1:0] next_pat;
   logic       lfsr_load;
   logic       lfsr_shift;
   logic [1:0] lfsr_bits;
   logic [1:0] lfsr_next_bits;

   jk_lfsr8 u_lfsr (
      .clk       (clk),
      .rst       (rst),
      .load      (lfsr_load),
      .seed      (SEED),
      .shift     (lfsr_shift),
      .out_bits  (lfsr_bits),
      .next_bits (lfsr_next_bits)
   );

   // Control strobes, compare result and the pattern for the step after this one
   always_comb begin
      lfsr_load  = ((state == ST_IDLE) || (state == ST_DONE)) && start;
      lfsr_shift = (state == ST_CHECK) && (step >= 8'(DIR_STEPS));
      mismatch   = (q_s != exp_q) || (qn_s != ~exp_q);
      err_inc    = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;
      step_inc   = step + 8'd1;
      if (step_inc < 8'(DIR_STEPS)) begin
         next_pat = DIR_PATTERN[step_inc[3:0]];
      end else if (lfsr_shift) begin
         // the LFSR advances on this same edge, so the next step uses its new value
         next_pat = lfsr_next_bits;
      end else begin
         next_pat = lfsr_bits;
      end
   end

   // Sequencer: DRIVE a pattern, WAIT for the slave, CHECK against the model
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_IDLE;
         J               <= 1'b0;
         K               <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         err_count       <= 8'h00;
         first_fail_step <= 8'hFF;
         step            <= 8'h00;
         exp_q           <= 1'b0;
         q_s             <= 1'b0;
         qn_s            <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state           <= ST_DRIVE;
                  step            <= 8'h00;
                  err_count       <= 8'h00;
                  first_fail_step <= 8'hFF;
                  {J, K}          <= DIR_PATTERN[0];
                  busy            <= 1'b1;
                  done            <= 1'b0;
                  pass            <= 1'b0;
               end
            end
            ST_DRIVE: begin
               exp_q  <= jk_next(exp_q, J, K);
               {J, K} <= JK_HOLD;
               state  <= ST_WAIT;
            end
            ST_WAIT: begin
               q_s   <= Q;
               qn_s  <= Qn;
               state <= ST_CHECK;
            end
            ST_CHECK: begin
               if (mismatch) begin
                  err_count <= err_inc;
                  if (err_count == 8'h00) begin
                     first_fail_step <= step;
                  end
               end
               if (step == LAST_STEP) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= !mismatch && (err_count == 8'h00);
               end else begin
                  step   <= step_inc;
                  {J, K} <= next_pat;
                  state  <= ST_DRIVE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jk_ff_bist.sv
// tb/tb_jk_ff_bist.sv - bench for jk_ff_bist with a behavioural flip-flop and fault injection
module tb_jk_ff_bist;

   localparam int NSTEPS = 32;
   localparam int RUNLEN = 3 * NSTEPS;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       J;
   logic       K;
   logic       Q;
   logic       Qn;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] err_count;
   logic [7:0] first_fail_step;

   int total = 0;
   int bad   = 0;

   int cyc = 0;
   int sc  = -1000;
   int fault_mode = 0;
   bit flip_at [NSTEPS];

   logic       m  = 1'b0;
   logic       qs = 1'b0;

   logic [1:0] exp_jk [NSTEPS];
   logic       exp_qv [NSTEPS];

   jk_ff_bist #(.RAND_STEPS(16), .SEED(8'hA5)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .J               (J),
      .K               (K),
      .Q               (Q),
      .Qn              (Qn),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .err_count       (err_count),
      .first_fail_step (first_fail_step)
   );

   always #5 clk = ~clk;

   function automatic logic jk_apply(input logic q, input logic [1:0] jk);
      if (jk == 2'b11) return ~q;
      if (jk == 2'b10) return 1'b1;
      if (jk == 2'b01) return 1'b0;
      return q;
   endfunction

   function automatic logic [7:0] lfsr_adv(input logic [7:0] s);
      return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
   endfunction

   function automatic bit flip_now(input int c, input int base);
      int rel;
      rel = c - base - 1;
      if (rel < 0 || (rel % 3) != 0 || (rel / 3) >= NSTEPS) return 1'b0;
      return flip_at[rel / 3];
   endfunction

   // Master stage captures J/K on the rising edge
   always @(posedge clk) begin
      cyc <= cyc + 1;
      m   <= jk_apply(m, {J, K});
   end

   // Slave stage follows the master on the falling edge; mode 3 corrupts chosen WAIT phases
   always @(negedge clk) begin
      if (fault_mode == 3 && flip_now(cyc, sc)) qs <= ~m;
      else qs <= m;
   end

   assign Q  = (fault_mode == 1) ? 1'b0 : qs;
   assign Qn = (fault_mode == 2) ? Q : ~Q;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic build_model();
      logic [1:0] dir [16];
      logic [7:0] s;
      logic       q;
      dir = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b11, 2'b11, 2'b11,
              2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00};
      s = 8'hA5;
      for (int i = 0; i < NSTEPS; i++) begin
         if (i < 16) begin
            exp_jk[i] = dir[i];
         end else begin
            exp_jk[i] = s[1:0];
            s = lfsr_adv(s);
         end
      end
      q = 1'b0;
      for (int i = 0; i < NSTEPS; i++) begin
         q = jk_apply(q, exp_jk[i]);
         exp_qv[i] = q;
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_jk"},   {30'd0, J, K}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
      chk({tag, "_err"},  {24'd0, err_count}, 32'd0);
      chk({tag, "_ffs"},  {24'd0, first_fail_step}, 32'hFF);
   endtask

   task automatic run(input string tag, input int mode, input int restart_c, input int abort_c);
      int  ec;
      int  ff;
      bit  b;
      ec = 0;
      ff = 255;
      fault_mode = mode;
      for (int s = 0; s < NSTEPS; s++) begin
         b = (mode == 2) || (mode == 1 && exp_qv[s]) || (mode == 3 && flip_at[s]);
         if (b) begin
            if (ff == 255) ff = s;
            if (ec < 255) ec++;
         end
      end
      @(negedge clk);
      start = 1'b1;
      sc = cyc + 1;
      for (int c = 0; c <= RUNLEN; c++) begin
         @(negedge clk);
         start = (c == restart_c);
         if (c < RUNLEN) begin
            chk({tag, "_seq"}, {28'd0, busy, done, J, K},
                {28'd0, 1'b1, 1'b0, ((c % 3) == 0) ? exp_jk[c / 3] : 2'b00});
         end else begin
            chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
            chk({tag, "_done"},     {31'd0, done}, 32'd1);
            chk({tag, "_pass"},     {31'd0, pass}, {31'd0, ec == 0});
            chk({tag, "_err"},      {24'd0, err_count}, ec);
            chk({tag, "_ffs"},      {24'd0, first_fail_step}, ff);
         end
         if (c == abort_c) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            sc = -1000;
            check_idle({tag, "_abort"});
            break;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      for (int s = 0; s < NSTEPS; s++) flip_at[s] = 1'b0;
      build_model();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_idle("reset");

      run("good", 0, -1, -1);
      run("again", 0, -1, -1);
      run("stuck0", 1, -1, -1);
      run("qn_eq_q", 2, -1, -1);

      for (int s = 0; s < NSTEPS; s++) flip_at[s] = ($urandom_range(0, 3) == 0);
      flip_at[$urandom_range(5, NSTEPS - 1)] = 1'b1;
      run("flips", 3, -1, -1);

      run("restart", 0, $urandom_range(2, RUNLEN - 6), -1);
      run("abort", 1, -1, 16);
      run("after_abort", 0, -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
